// File: rtl/bus_target_pkg.sv
// Shared types, constants and address decode helper for the bus target.
package bus_target_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Width of the read wait-state counter (0..7 wait states).
  localparam int unsigned WS_W = 3;

  // True when addr is a real strobe (nonzero) and falls inside the
  // nregs-word window starting at base. Evaluated in 64 bits so the
  // window limit cannot wrap for any legal base.
  function automatic logic in_window(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input int unsigned nregs);
    logic [63:0] limit;
    limit = base + (64'(nregs) << 2);
    return (addr != '0) && (addr >= base) && (addr < limit);
  endfunction

endpackage

// File: rtl/bus_target_waitgen.sv
// Loadable down-counter that stalls the core for the read wait states
// and pulses done in the last stalled cycle.
module bus_target_waitgen
  import bus_target_pkg::*;
(
  input  logic            clk_i,
  input  logic            reset_n_i,
  input  logic            load_i,
  input  logic [WS_W-1:0] load_val_i,
  output logic            halt_o,
  output logic            done_o
);

  logic [WS_W-1:0] cnt_q;

  // Count down the remaining wait states; halt is a flop so it never glitches.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      halt_o <= 1'b0;
    end else if (load_i && (load_val_i != '0)) begin
      cnt_q  <= load_val_i;
      halt_o <= 1'b1;
    end else if (halt_o) begin
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == WS_W'(1)) begin
        halt_o <= 1'b0;
      end
    end
  end

  assign done_o = halt_o && (cnt_q == WS_W'(1));

endmodule

// File: rtl/bus_target_regs.sv
// Memory-mapped register bank on the CPU native bus: byte-masked writes,
// reads returned after a programmable number of wait states.
module bus_target_regs
  import bus_target_pkg::*;
#(
  parameter int unsigned               address_width = 32,
  parameter logic [address_width-1:0]  BaseAddress   = address_width'(32'h0000_9000),
  parameter int unsigned               NumRegs       = 8,
  parameter int unsigned               WaitStates    = 2,
  parameter logic [NumRegs-1:0]        ReadOnlyMask  = '0
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] address_i,
  input  logic [31:0]              data_i,
  input  logic                     we_i,
  input  logic [3:0]               we_ram_i,
  input  logic [NumRegs*32-1:0]    status_i,
  output logic [31:0]              data_o,
  output logic                     halt_o,
  output logic [NumRegs*32-1:0]    reg_o,
  output logic                     proto_err_o
);

  localparam int unsigned IdxW = (NumRegs > 1) ? $clog2(NumRegs) : 1;

  state_t          state_q, state_d;
  logic [31:0]     regs [NumRegs];
  logic [31:0]     status_arr [NumRegs];
  logic            strobe, hit;
  logic [IdxW-1:0] idx, rd_idx_q, rd_sel;
  logic [31:0]     rd_value;
  logic            wr_en, rd_capture, wg_load, wg_done, err_set;

  assign strobe = |address_i;
  assign hit    = in_window(64'(address_i), 64'(BaseAddress), NumRegs);
  assign idx    = IdxW'((address_i - BaseAddress) >> 2);

  for (genvar k = 0; k < NumRegs; k++) begin : g_flat
    assign reg_o[32*k +: 32] = regs[k];
    assign status_arr[k]     = status_i[32*k +: 32];
  end

  // With zero wait states the response edge is the strobe edge, so the
  // index comes straight from the bus instead of the captured copy.
  assign rd_sel   = (state_q == IDLE) ? idx : rd_idx_q;
  assign rd_value = ReadOnlyMask[rd_sel] ? status_arr[rd_sel] : regs[rd_sel];

  bus_target_waitgen u_waitgen (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .load_i     (wg_load),
    .load_val_i (WS_W'(WaitStates)),
    .halt_o     (halt_o),
    .done_o     (wg_done)
  );

  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next-state decode; only IDLE accepts transactions, any strobe while
  // a read is pending is a protocol error.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    rd_capture = 1'b0;
    wg_load    = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (we_i) begin
            wr_en = 1'b1;
          end else begin
            rd_capture = 1'b1;
            if (WaitStates == 0) begin
              state_d = RESP;
            end else begin
              wg_load = 1'b1;
              state_d = WAIT;
            end
          end
        end
      end
      WAIT: begin
        err_set = strobe;
        if (wg_done) state_d = RESP;
      end
      RESP: begin
        err_set = strobe;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response data, captured read index and sticky protocol error.
  // data_o is zero except for the single cycle spent in RESP; a strobe
  // landing on the response edge is already an error and does not
  // suppress the pending data.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_o      <= '0;
      rd_idx_q    <= '0;
      proto_err_o <= 1'b0;
    end else begin
      data_o <= (state_d == RESP) ? rd_value : '0;
      if (rd_capture) rd_idx_q    <= idx;
      if (err_set)    proto_err_o <= 1'b1;
    end
  end

  // Register bank with byte-masked writes; read-only slots never change.
  // NOTE: the bank is reset because its contents are architecturally
  // visible on reg_o; a plain storage RAM would be left unreset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < NumRegs; k++) regs[k] <= '0;
    end else begin
      for (int k = 0; k < NumRegs; k++) begin
        if (wr_en && !ReadOnlyMask[k] && (idx == IdxW'(k))) begin
          for (int b = 0; b < 4; b++) begin
            if (we_ram_i[b]) regs[k][8*b +: 8] <= data_i[8*b +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_target_regs.sv
// Directed bench for bus_target_regs: writes, wait-stated reads,
// read-only registers, misses, protocol errors and mid-read reset.
module tb_bus_target_regs;

  localparam logic [31:0] BASE = 32'h0000_9000;

  logic         clk_i = 1'b0;
  logic         reset_n_i;
  logic [31:0]  address_i, address2_i;
  logic [31:0]  data_i;
  logic         we_i;
  logic [3:0]   we_ram_i;
  logic [255:0] status_i;

  logic [31:0]  data_o, data2_o;
  logic         halt_o, halt2_o;
  logic [255:0] reg_o, reg2_o;
  logic         proto_err_o, proto_err2_o;

  int checks   = 0;
  int failures = 0;
  logic [255:0] exp_bank;

  // Main instance: two wait states, register 0 read-only.
  bus_target_regs #(
    .BaseAddress (BASE),
    .NumRegs     (8),
    .WaitStates  (2),
    .ReadOnlyMask(8'h01)
  ) dut (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .address_i  (address_i),
    .data_i     (data_i),
    .we_i       (we_i),
    .we_ram_i   (we_ram_i),
    .status_i   (status_i),
    .data_o     (data_o),
    .halt_o     (halt_o),
    .reg_o      (reg_o),
    .proto_err_o(proto_err_o)
  );

  // Second instance: three wait states, own address bus.
  bus_target_regs #(
    .BaseAddress (BASE),
    .NumRegs     (8),
    .WaitStates  (3)
  ) dut2 (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .address_i  (address2_i),
    .data_i     (data_i),
    .we_i       (we_i),
    .we_ram_i   (we_ram_i),
    .status_i   (status_i),
    .data_o     (data2_o),
    .halt_o     (halt2_o),
    .reg_o      (reg2_o),
    .proto_err_o(proto_err2_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] be);
    address_i = a;
    we_i      = w;
    data_i    = d;
    we_ram_i  = be;
  endtask

  task automatic bus_idle();
    address_i  = '0;
    address2_i = '0;
    we_i       = 1'b0;
    data_i     = '0;
    we_ram_i   = '0;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk_i);
  endtask

  initial begin
    reset_n_i = 1'b0;
    status_i  = '0;
    bus_idle();

    // Reset state
    tick();
    check("rst_halt", halt_o, 0);
    check("rst_data", data_o, 0);
    check("rst_err",  proto_err_o, 0);
    check("rst_regs", reg_o, '0);

    // Release and write on the first edge after release
    tick();
    reset_n_i = 1'b1;
    bus(BASE + 4, 1'b1, 32'hDEAD_BEEF, 4'hF);
    tick();
    check("wr_full", reg_o[63:32], 32'hDEAD_BEEF);
    check("wr_halt", halt_o, 0);
    bus(BASE + 4, 1'b1, 32'h0000_0012, 4'b0001);
    tick();
    bus_idle();
    check("wr_byte0", reg_o[63:32], 32'hDEAD_BE12);
    check("wr_data0", data_o, 0);

    // Read with two wait states
    bus(BASE + 4, 1'b0, 32'h0, 4'h0);
    tick();
    bus_idle();
    check("rd_s1_halt", halt_o, 1);
    check("rd_s1_data", data_o, 0);
    tick();
    check("rd_s2_halt", halt_o, 1);
    check("rd_s2_data", data_o, 0);
    tick();
    check("rd_s3_halt", halt_o, 0);
    check("rd_s3_data", data_o, 32'hDEAD_BE12);
    tick();
    check("rd_s4_halt", halt_o, 0);
    check("rd_s4_data", data_o, 0);

    // Read-only register 0
    status_i[31:0] = 32'h1234_5678;
    bus(BASE, 1'b1, 32'hFFFF_FFFF, 4'hF);
    tick();
    bus_idle();
    check("ro_unchanged", reg_o[31:0], 0);
    bus(BASE, 1'b0, 32'h0, 4'h0);
    tick();
    bus_idle();
    check("ro_s1_halt", halt_o, 1);
    tick();
    check("ro_s2_halt", halt_o, 1);
    tick();
    check("ro_s3_data", data_o, 32'h1234_5678);
    tick();
    check("ro_s4_data", data_o, 0);

    // Misses just past the top and just below the base
    exp_bank = '0;
    exp_bank[63:32] = 32'hDEAD_BE12;
    bus(BASE + 32, 1'b1, 32'hAAAA_AAAA, 4'hF);
    tick();
    bus(BASE - 4, 1'b1, 32'h5555_5555, 4'hF);
    tick();
    check("miss_wr_regs", reg_o, exp_bank);
    bus(BASE + 32, 1'b0, 32'h0, 4'h0);
    tick();
    bus(BASE - 4, 1'b0, 32'h0, 4'h0);
    tick();
    bus_idle();
    check("miss_rd_halt", halt_o, 0);
    check("miss_rd_data", data_o, 0);
    tick();
    check("miss_rd_halt2", halt_o, 0);
    check("miss_rd_data2", data_o, 0);
    check("miss_err", proto_err_o, 0);
    check("miss_regs", reg_o, exp_bank);

    // Protocol error on the three-wait-state instance
    address2_i = BASE + 8;
    we_i = 1'b1; data_i = 32'h5555_AAAA; we_ram_i = 4'hF;
    tick();
    address2_i = BASE + 8;
    we_i = 1'b0; data_i = '0; we_ram_i = '0;
    tick();
    address2_i = BASE;
    we_i = 1'b1; data_i = 32'hFFFF_FFFF; we_ram_i = 4'hF;
    check("pe_s1_halt", halt2_o, 1);
    check("pe_s1_err",  proto_err2_o, 0);
    tick();
    bus_idle();
    check("pe_s2_halt", halt2_o, 1);
    check("pe_s2_err",  proto_err2_o, 1);
    check("pe_s2_reg0", reg2_o[31:0], 0);
    tick();
    check("pe_s3_halt", halt2_o, 1);
    check("pe_s3_data", data2_o, 0);
    tick();
    check("pe_s4_halt", halt2_o, 0);
    check("pe_s4_data", data2_o, 32'h5555_AAAA);
    tick();
    check("pe_s5_data", data2_o, 0);
    check("pe_sticky",  proto_err2_o, 1);

    // Asynchronous reset in the middle of a pending read
    bus(BASE + 4, 1'b0, 32'h0, 4'h0);
    tick();
    bus_idle();
    check("ar_halt_pre", halt_o, 1);
    #1 reset_n_i = 1'b0;
    #1;
    check("ar_halt", halt_o, 0);
    check("ar_data", data_o, 0);
    check("ar_regs", reg_o, '0);
    check("ar_err2", proto_err2_o, 0);
    tick();
    reset_n_i = 1'b1;
    bus(BASE + 12, 1'b1, 32'h0BAD_F00D, 4'b1100);
    tick();
    check("ar_wr", reg_o[127:96], 32'h0BAD_0000);
    bus(BASE + 12, 1'b0, 32'h0, 4'h0);
    tick();
    bus_idle();
    check("ar_rd_s1_halt", halt_o, 1);
    tick();
    check("ar_rd_s2_halt", halt_o, 1);
    tick();
    check("ar_rd_s3_data", data_o, 32'h0BAD_0000);
    check("ar_rd_s3_halt", halt_o, 0);
    tick();
    check("ar_rd_s4_data", data_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
